rv32im_fetch: RTL and testbench
===============================

# rv32im_fetch

Instruction fetch unit for the RV32IM core: owns the program counter, fetches instruction words from instruction memory over a request/acknowledge handshake, and presents them to `rv32im_decode` (drives its `instruction_i`, `pc_data_i`, `data_ready_i`, `interrupt_trigger_i`). It consumes the decoder's control-flow feedback: it stalls after any control-transfer instruction until a redirect or resume arrives. It also inserts interrupt entry at instruction boundaries.

## Interface
- `XLEN`, 32, data/address width
- `ILEN`, 32, instruction width
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset
- `IRQ_VECTOR`, 32'h0000_0010, interrupt handler entry address

- `clk_i`  in  1  single clock; all logic is on the rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `mem_req_o`  out  1  instruction memory request
- `mem_addr_o`  out  XLEN  fetch address, word aligned, stable while `mem_req_o`
- `mem_ack_i`  in  1  memory has `mem_data_i` valid; ignored unless `mem_req_o`
- `mem_data_i`  in  ILEN  fetched instruction word
- `instruction_o`  out  ILEN  instruction word to decode
- `pc_data_o`  out  XLEN  PC of `instruction_o`, or the return PC during `interrupt_trigger_o`
- `data_ready_o`  out  1  `instruction_o`/`pc_data_o` valid for decode
- `stall_i`  in  1  downstream cannot accept this cycle
- `processing_jump_i`  in  1  decoder flag, combinational from `instruction_o`
- `redirect_i`  in  1  taken control transfer
- `redirect_pc_i`  in  XLEN  target PC
- `resume_i`  in  1  control instruction resolved not-taken; continue at PC+4
- `mret_i`  in  1  accompanies the `redirect_i` of an MRET; leaves handler mode
- `irq_i`  in  1  level interrupt request
- `interrupt_trigger_o`  out  1  one-cycle interrupt-entry pulse

## Operation
- States: IDLE, REQ, PRESENT, JUMP_WAIT, IRQ.
- IDLE: this is the reset state. It moves to REQ unconditionally on the next edge.
- REQ:
  - `mem_req_o`=1 and `mem_addr_o`=pc.
  - On `mem_ack_i`, latch `mem_data_i` into `instruction_o` and go to PRESENT.
  - Wait states are unbounded.
- PRESENT: `data_ready_o`=1. A transfer occurs when `data_ready_o & ~stall_i`. On transfer:
  - if `processing_jump_i`, go to JUMP_WAIT;
  - otherwise next_pc = pc+4, then take the boundary step.
  - If `stall_i` is high, hold the instruction, PC and outputs unchanged.
- JUMP_WAIT: `data_ready_o`=0.
  - On `redirect_i`, next_pc = {`redirect_pc_i`[XLEN-1:2],2'b00}.
  - Else on `resume_i`, next_pc = pc+4.
  - Then take the boundary step.
  - If both arrive in the same cycle, `redirect_i` wins.
  - If `mret_i` is high together with `redirect_i`, clear `in_handler`.
- Boundary step:
  - If `irq_i & ~in_handler`: `ret_pc` <= next_pc, pc <= IRQ_VECTOR, `in_handler` <= 1, go to IRQ.
  - Otherwise pc <= next_pc and go to REQ.
- IRQ: this state lasts one cycle.
  - `interrupt_trigger_o`=1 and `pc_data_o`=`ret_pc`, so the decoder captures its `uepc`.
  - `data_ready_o`=0 and `mem_req_o`=0.
  - Then go to REQ.
- `redirect_i`, `resume_i` and `mret_i` are ignored outside JUMP_WAIT.
- `irq_i` is sampled only at the boundary step; there is no nesting while `in_handler`.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - state=IDLE, pc=`mem_addr_o`=RESET_VECTOR;
  - `mem_req_o`=0, `data_ready_o`=0, `interrupt_trigger_o`=0;
  - `instruction_o`=0, `pc_data_o`=0, `in_handler`=0, `ret_pc`=0.
- Reset asserted mid-request or mid-presentation drops `mem_req_o`/`data_ready_o` immediately (asynchronous). The pending ack is discarded.
- The first request is asserted in the second cycle after reset release.
- Ack in cycle N gives `data_ready_o` in cycle N+1.
- A non-jump transfer in cycle N+1 gives the next `mem_req_o` in cycle N+2.
- Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- `mem_ack_i` may arrive in the first cycle of `mem_req_o`.
- A redirect or resume in cycle M gives `mem_req_o` with the new address in cycle M+1, or the IRQ pulse in M+1 and the request in M+2.
- `pc_data_o` is updated together with `instruction_o` and held until the next ack or IRQ.
- `processing_jump_i` is sampled only on a transfer cycle.

## Test plan
- Reset release, memory acks every request with 0 wait, no jumps:
  - addresses 0,4,8,12 appear on every other cycle;
  - `data_ready_o` pulses with matching `pc_data_o`.
- Ack delayed 3 cycles and `stall_i` held 2 cycles in PRESENT:
  - `mem_addr_o` is stable during the wait;
  - `instruction_o`/`pc_data_o` are held during the stall;
  - exactly one transfer occurs.
- JAL at pc=8 (`processing_jump_i`=1), `redirect_i` 1 cycle later with target 32'h103:
  - no request is issued while waiting;
  - the next fetch address is 32'h100.
- Branch at pc=16 with `resume_i` → next fetch at 20. Then a separate case with `redirect_i` and `resume_i` simultaneous, target 64 → next fetch at 64.
- `irq_i` high during a transfer of pc=24 (non-jump):
  - IRQ pulse with `pc_data_o`=28, then fetch at 32'h10;
  - a second `irq_i` in the handler is ignored until MRET (`redirect_i`+`mret_i`, target 28) resumes at 28.
- Assert `rst_i` while `mem_req_o` is high at pc=40:
  - outputs go to reset values within the cycle;
  - after release, the fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/rv32im_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
// Signal names follow the fetch unit's point of view.
interface rv32im_fetch_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_ack_i;
    logic [ILEN-1:0] mem_data_i;

    modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_data_i);
    modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_data_i);
endinterface

// File: rtl/rv32im_fetch.sv
// RV32IM fetch unit: owns the PC, fetches over a req/ack bus, presents words to
// decode, waits on control-flow feedback and inserts interrupt entry at boundaries.
module rv32im_fetch #(
    parameter int              XLEN         = 32,
    parameter int              ILEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] IRQ_VECTOR   = 32'h0000_0010
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rv32im_fetch_if.master   mem,
    output logic [ILEN-1:0]  instruction_o,
    output logic [XLEN-1:0]  pc_data_o,
    output logic             data_ready_o,
    input  logic             stall_i,
    input  logic             processing_jump_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             resume_i,
    input  logic             mret_i,
    input  logic             irq_i,
    output logic             interrupt_trigger_o
);
    typedef enum logic [2:0] {IDLE, REQ, PRESENT, JUMP_WAIT, IRQ} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_data_q, pc_data_d;
    logic [XLEN-1:0] ret_pc_q, ret_pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            in_handler_q, in_handler_d;
    logic            boundary;
    logic [XLEN-1:0] next_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            pc_data_q    <= '0;
            ret_pc_q     <= '0;
            instr_q      <= '0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_data_q    <= pc_data_d;
            ret_pc_q     <= ret_pc_d;
            instr_q      <= instr_d;
            in_handler_q <= in_handler_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_data_d    = pc_data_q;
        ret_pc_d     = ret_pc_q;
        instr_d      = instr_q;
        in_handler_d = in_handler_q;
        boundary     = 1'b0;
        next_pc      = pc_q + XLEN'(4);
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (mem.mem_ack_i) begin
                    instr_d   = mem.mem_data_i;
                    pc_data_d = pc_q;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (!stall_i) begin
                    if (processing_jump_i) state_d = JUMP_WAIT;
                    else                   boundary = 1'b1;
                end
            end
            JUMP_WAIT: begin
                if (redirect_i) begin
                    next_pc  = redirect_pc_i & ~XLEN'(3);
                    boundary = 1'b1;
                    if (mret_i) in_handler_d = 1'b0;
                end else if (resume_i) begin
                    boundary = 1'b1;
                end
            end
            IRQ:     state_d = REQ;
            default: state_d = IDLE;
        endcase
        // Interrupt entry decision uses the handler flag as it was this cycle.
        if (boundary) begin
            if (irq_i && !in_handler_q) begin
                ret_pc_d     = next_pc;
                pc_d         = IRQ_VECTOR;
                in_handler_d = 1'b1;
                state_d      = IRQ;
            end else begin
                pc_d    = next_pc;
                state_d = REQ;
            end
        end
    end

    assign mem.mem_req_o       = (state_q == REQ);
    assign mem.mem_addr_o      = pc_q;
    assign instruction_o       = instr_q;
    assign data_ready_o        = (state_q == PRESENT);
    assign interrupt_trigger_o = (state_q == IRQ);
    assign pc_data_o           = (state_q == IRQ) ? ret_pc_q : pc_data_q;
endmodule

// File: tb/tb_rv32im_fetch.sv
// Directed bench for rv32im_fetch: memory/decoder stand-ins, a transaction-level
// reference of the fetch flow checked every cycle, and literal pins on the flow.
module tb_rv32im_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32im_fetch_if bus();
    logic [31:0] instr, pcd, redirect_pc;
    logic dr, stall, pj, redirect, resume, mret, irq, trig;

    rv32im_fetch dut (
        .clk_i(clk), .rst_i(rst), .mem(bus),
        .instruction_o(instr), .pc_data_o(pcd), .data_ready_o(dr),
        .stall_i(stall), .processing_jump_i(pj),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .resume_i(resume), .mret_i(mret), .irq_i(irq),
        .interrupt_trigger_o(trig)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Program image: control-transfer opcodes at the listed addresses.
    function automatic logic is_jump(input logic [31:0] a);
        return (a == 32'h8) || (a == 32'h104) || (a == 32'h10) || (a == 32'h14) || (a == 32'h40);
    endfunction
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[24:0], is_jump(a) ? 7'h6F : 7'h13};
    endfunction
    function automatic int ack_wait(input logic [31:0] a);
        if (a == 32'h100) return 3;
        if (a == 32'h28)  return 1000;
        return 0;
    endfunction

    assign bus.mem_data_i = word(bus.mem_addr_o);
    assign pj = (instr[6:0] == 7'h6F);

    // Decoder responses to successive control-transfer instructions.
    int          r_dly[9] = '{0, 2, 1, 0, 0, 0, 1, 0, 0};
    bit          r_rd[9]  = '{1, 1, 0, 1, 1, 0, 1, 0, 1};
    bit          r_rs[9]  = '{0, 0, 1, 1, 0, 1, 0, 1, 0};
    bit          r_mr[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    logic [31:0] r_tgt[9] = '{32'h103, 32'hC, 32'h300, 32'h40, 32'h18, 32'h300, 32'h1C, 32'h300, 32'h24};

    int wcnt = 0, ridx = 0, cwait = 0, stall_cnt = 0;
    bit cact = 0, irq_hold = 0, irq_first = 1, p_dr = 0, p_st = 0, p_pj = 0;

    initial begin
        bus.mem_ack_i = 0; stall = 0; redirect = 0; resume = 0;
        mret = 0; redirect_pc = 0; irq = 0;
    end

    always @(posedge clk) begin
        #1;
        redirect = 0; resume = 0; mret = 0; redirect_pc = 0; stall = 0;
        if (rst) begin
            wcnt = 0; cact = 0; p_dr = 0; bus.mem_ack_i = 0; irq = 0;
        end else begin
            if (bus.mem_req_o) begin
                if (wcnt >= ack_wait(bus.mem_addr_o)) bus.mem_ack_i = 1;
                else begin bus.mem_ack_i = 0; wcnt++; end
            end else begin
                bus.mem_ack_i = 0; wcnt = 0;
            end
            if (dr && pcd == 32'h100 && stall_cnt < 2) begin stall = 1; stall_cnt++; end
            // Stray redirect while presenting a plain instruction must be ignored.
            if (dr && pcd == 32'h4) begin redirect = 1; redirect_pc = 32'h200; end
            if (p_dr && !p_st && p_pj && ridx < 9) begin cact = 1; cwait = r_dly[ridx]; end
            if (cact) begin
                if (cwait == 0) begin
                    redirect = r_rd[ridx]; resume = r_rs[ridx]; mret = r_mr[ridx];
                    redirect_pc = r_tgt[ridx]; ridx++; cact = 0;
                end else cwait--;
            end
            if (trig && irq_first) begin irq_hold = 1; irq_first = 0; end
            if (dr && pcd == 32'h14) irq_hold = 0;
            irq = irq_hold || (dr && (pcd == 32'h18 || pcd == 32'h20));
            p_dr = dr; p_st = stall; p_pj = pj;
        end
    end

    // Reference: where the fetch stream is, what must be fetched/presented next.
    typedef enum int {M_START, M_FETCH, M_PRES, M_CTRL, M_ENTRY} ph_e;
    ph_e         ph = M_START;
    logic [31:0] e_addr = 0, e_pc = 0, e_ret = 0;
    bit          hnd = 0, prev_req = 0;
    int          cyc = 0;
    logic [31:0] xfer_log[$], ret_log[$];
    int          req_start[$];

    task take_boundary(input logic [31:0] n, input bit h_old);
        if (irq && !h_old) begin
            e_ret = n; e_addr = 32'h10; hnd = 1; ph = M_ENTRY;
        end else begin
            e_addr = n; ph = M_FETCH;
        end
    endtask

    always @(negedge clk) begin
        bit h_old;
        cyc++;
        if (rst) begin
            check("rst_req",   bus.mem_req_o,  0);
            check("rst_addr",  bus.mem_addr_o, 0);
            check("rst_ready", dr,    0);
            check("rst_trig",  trig,  0);
            check("rst_instr", instr, 0);
            check("rst_pc",    pcd,   0);
            ph = M_START; e_addr = 0; hnd = 0; prev_req = 0;
        end else begin
            check("mem_req",    bus.mem_req_o, 32'(ph == M_FETCH));
            check("data_ready", dr,            32'(ph == M_PRES));
            check("irq_pulse",  trig,          32'(ph == M_ENTRY));
            if (ph == M_FETCH) check("mem_addr", bus.mem_addr_o, e_addr);
            if (ph == M_PRES) begin
                check("pres_pc",    pcd,   e_pc);
                check("pres_instr", instr, word(e_pc));
            end
            if (ph == M_ENTRY) check("irq_ret_pc", pcd, e_ret);
            if (bus.mem_req_o && !prev_req) req_start.push_back(cyc);
            prev_req = bus.mem_req_o;
            h_old = hnd;
            case (ph)
                M_START: ph = M_FETCH;
                M_FETCH: if (bus.mem_ack_i) begin e_pc = e_addr; ph = M_PRES; end
                M_PRES: if (!stall) begin
                    xfer_log.push_back(e_pc);
                    if (pj) ph = M_CTRL;
                    else    take_boundary(e_pc + 32'd4, h_old);
                end
                M_CTRL: begin
                    if (redirect) begin
                        if (mret) hnd = 0;
                        take_boundary({redirect_pc[31:2], 2'b00}, h_old);
                    end else if (resume) take_boundary(e_pc + 32'd4, h_old);
                end
                M_ENTRY: begin ret_log.push_back(e_ret); ph = M_FETCH; end
                default: ph = M_START;
            endcase
        end
    end

    task summary;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    initial begin
        repeat (4000) @(posedge clk);
        $display("FAIL watchdog: run did not complete, expected completion within 4000 cycles");
        n_fail++;
        summary();
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_xfer[18] = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'hC, 32'h10, 32'h14, 32'h40,
                                  32'h18, 32'h10, 32'h14, 32'h1C, 32'h20, 32'h10, 32'h14, 32'h24, 32'h0};
    logic [31:0] exp_ret[2] = '{32'h1C, 32'h24};

    initial begin
        int n;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk); check("first_cycle_no_req", bus.mem_req_o, 0);
        @(negedge clk); check("second_cycle_req", bus.mem_req_o, 1);
        check("second_cycle_addr", bus.mem_addr_o, 32'h0);

        n = 0;
        while (!(bus.mem_req_o && bus.mem_addr_o == 32'h28) && n < 3000) begin
            @(posedge clk); #2; n++;
        end
        check("reached_fetch_40", 32'(bus.mem_req_o && bus.mem_addr_o == 32'h28), 1);
        #1 rst = 1;
        #1;
        check("async_rst_req",   bus.mem_req_o,  0);
        check("async_rst_addr",  bus.mem_addr_o, 0);
        check("async_rst_ready", dr,    0);
        check("async_rst_pc",    pcd,   0);
        check("async_rst_instr", instr, 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 0;

        n = 0;
        while (!(dr && pcd == 32'h4) && n < 200) begin @(posedge clk); #2; n++; end
        check("restart_presents_4", 32'(dr && pcd == 32'h4), 1);
        repeat (2) @(negedge clk);

        check("req_starts_seen", 32'(req_start.size() >= 3), 1);
        if (req_start.size() >= 3) begin
            check("req_gap_0_4", 32'(req_start[1] - req_start[0]), 2);
            check("req_gap_4_8", 32'(req_start[2] - req_start[1]), 2);
        end
        check("xfer_count", 32'(xfer_log.size() >= 18), 1);
        for (int i = 0; i < 18 && i < xfer_log.size(); i++)
            check($sformatf("xfer_%0d", i), xfer_log[i], exp_xfer[i]);
        check("irq_count", 32'(ret_log.size()), 2);
        for (int i = 0; i < 2 && i < ret_log.size(); i++)
            check($sformatf("irq_ret_%0d", i), ret_log[i], exp_ret[i]);
        summary();
        $finish;
    end
endmodule
